// File: rtl/cpu_pkg.sv
// cpu_pkg: datapath constants shared by the pipeline buffers, decode and writeback
package cpu_pkg;
    localparam int DATA_W   = 32;
    localparam int REG_AW   = 6;
    localparam int NUM_REGS = 64;
    localparam int CNT_W    = 32;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register storage with async clear, one write port, two raw read ports
module regfile_2r1w
    import cpu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW,
    parameter int N  = NUM_REGS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra0,
    input  logic [AW-1:0] ra1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1
);
    logic [DW-1:0] r_mem [N];

    // every register is writable, register 0 included; reset clears all of them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        else if (we)
            r_mem[waddr] <= wdata;
    end

    assign rd0 = r_mem[ra0];
    assign rd1 = r_mem[ra1];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux, bypassed register file, jump-from-memory redirect, write counter
module wb_regfile #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CNT_W  = cpu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Jm_in,
    input  logic              RegWrt_in,
    input  logic              ALUtoReg_in,
    input  logic [DATA_W-1:0] mem_res_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              jump_valid,
    output logic [DATA_W-1:0] jump_target,
    output logic [CNT_W-1:0]  wb_count
);
    logic [DATA_W-1:0] w_wb_data, w_rs_raw, w_rt_raw;
    logic              w_we;
    logic              r_jv;
    logic [DATA_W-1:0] r_jt;
    logic [CNT_W-1:0]  r_cnt;

    assign w_wb_data = ALUtoReg_in ? alu_res_in : mem_res_in;
    assign w_we      = RegWrt_in && rst_n;

    regfile_2r1w #(.DW(DATA_W), .AW(REG_AW), .N(cpu_pkg::NUM_REGS)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we),
        .waddr (rd_in),
        .wdata (w_wb_data),
        .ra0   (rs_addr),
        .ra1   (rt_addr),
        .rd0   (w_rs_raw),
        .rd1   (w_rt_raw)
    );

    // forward the value being written this cycle so decode never sees stale data
    always_comb begin
        rs_data = (w_we && rd_in == rs_addr) ? w_wb_data : w_rs_raw;
        rt_data = (w_we && rd_in == rt_addr) ? w_wb_data : w_rt_raw;
    end

    // redirect pulse follows Jm_in; the target always comes from memory data and holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jv <= 1'b0;
            r_jt <= '0;
        end else begin
            r_jv <= Jm_in;
            if (Jm_in) r_jt <= mem_res_in;
        end
    end

    // count committed writes, wrapping silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_cnt <= '0;
        else if (RegWrt_in) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign jump_valid  = r_jv;
    assign jump_target = r_jt;
    assign wb_count    = r_cnt;
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file. It consumes the registered outputs of the EX/MEM-to-WB pipeline buffer, selects the writeback value, and commits it into a 64 x 32 register file. It serves two combinational read ports with same-cycle write-through bypass for the decode stage. It also emits a registered jump-from-memory redirect and a retired-write counter.

## Interface
- DATA_W, 32, datapath and register width
- REG_AW, 6, register address width (64 registers)
- CNT_W, 32, width of the retired-write counter
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Jm_in  in  1  jump-from-memory request from the WB buffer
- RegWrt_in  in  1  register write enable
- ALUtoReg_in  in  1  writeback select: 1 = alu_res_in, 0 = mem_res_in
- mem_res_in  in  DATA_W  memory read data
- alu_res_in  in  DATA_W  ALU result
- rd_in  in  REG_AW  destination register
- rs_addr, rt_addr  in  REG_AW  read port addresses
- rs_data, rt_data  out  DATA_W  read port data (combinational)
- jump_valid  out  1  registered one-cycle redirect pulse
- jump_target  out  DATA_W  registered redirect target
- wb_count  out  CNT_W  number of committed register writes

## Operation
- wb_data = ALUtoReg_in ? alu_res_in : mem_res_in. The select is combinational.
- Commit: on each rising edge with rst_n=1 and RegWrt_in=1, regs[rd_in] <= wb_data. Every register is writable, including register 0. No register is hardwired.
- Reads: rs_data = (RegWrt_in && rst_n && rd_in==rs_addr) ? wb_data : regs[rs_addr]. rt_data follows the same rule with rt_addr.
- The bypass delivers a value in the same cycle it is being written. The decode stage therefore never sees stale data from the instruction currently in writeback.
- Both ports may address the same register, and that register may also equal rd_in. Both ports then return wb_data.
- Jump: on the rising edge with Jm_in=1:
  - jump_valid <= 1
  - jump_target <= mem_res_in, independent of ALUtoReg_in
- When Jm_in=0 at the edge, jump_valid <= 0 and jump_target holds its value.
- Jm_in and RegWrt_in may both be asserted in one cycle. The jump and the register write both take effect.
- wb_count increments by 1 on every committed write. It wraps from 2^CNT_W-1 to 0 with no flag.

## Timing
- Reset (rst_n=0, asynchronous, no clock needed):
  - all 64 registers = 0
  - jump_valid = 0, jump_target = 0, wb_count = 0
- While rst_n=0:
  - writes, jump capture and counting are suppressed
  - the bypass is disabled, so read ports return 0
- Reset deasserted: the first edge with rst_n=1 may commit.
- Reset asserted mid-operation: any write pending on that edge is lost. State clears immediately.
- Write latency: a value is visible via the bypass in cycle N. It is visible from storage in cycle N+1 onward.
- Redirect latency: Jm_in is sampled at edge N. jump_valid is high for exactly the cycle after edge N.
  - Consecutive Jm_in cycles give jump_valid high continuously.
  - jump_target then updates on each edge.
- No handshake or back-pressure. The block accepts one writeback per cycle, unconditionally.

## Structure
- Shared package cpu_pkg holds DATA_W, REG_AW, NUM_REGS=64 and CNT_W. The pipeline buffers and the decode stage use the same constants.
- Sub-module regfile_2r1w contains the storage array, the asynchronous clear, one write port and two raw read ports.
- The top level contains:
  - the writeback mux
  - the bypass comparators
  - the jump register
  - the counter

## Test plan
- Reset clears state: write regs[5]=0xDEADBEEF, then pulse rst_n low between clock edges. Required: rs_data at addr 5 reads 0 immediately; jump_valid=0; wb_count=0.
- Writeback select and commit:
  - RegWrt=1, ALUtoReg=1, alu=0x11, mem=0x22, rd=3 → regs[3]=0x11.
  - Next cycle ALUtoReg=0, rd=4 → regs[4]=0x22.
  - wb_count=2.
- Bypass with a dual hit: rs_addr=rt_addr=rd_in=9, RegWrt=1, wb_data=0xCAFE0001, old regs[9]=0x7. Required: both ports read 0xCAFE0001 in the same cycle and in the following cycle. With RegWrt=0 the ports read 0x7.
- Jump with a simultaneous write: Jm=1, RegWrt=1, ALUtoReg=1, mem=0x400, alu=0x55, rd=31. Required:
  - jump_valid=1 for one cycle, jump_target=0x400
  - regs[31]=0x55
  - after Jm drops, jump_valid=0 and jump_target stays 0x400
- Counter wrap: with CNT_W=4, perform 17 writes → wb_count=1.
- Reset mid-write: assert rst_n low coincident with RegWrt=1, rd=2, data=0xFF. Required: regs[2]=0 after deassert; wb_count=0.
